me_skew_window_buf: RTL

//  Parametrised skewed reference-window buffer for the motion-estimation SAD array.

---
 rtl/me_pkg.sv | 30 +++
 rtl/me_skew_stage.sv | 39 +++
 rtl/me_skew_window_buf.sv | 82 ++++++++
 3 files changed

// File: rtl/me_pkg.sv
// Shared types and sizing helpers for the motion-estimation reference-window buffer.
// Stage k of the skew buffer holds pixels k..IN_PIX-1 of a segment, so its width
// shrinks by one pixel per stage; the helpers below keep that arithmetic in one place.
package me_pkg;

  localparam int ME_PIX_W = 8;

  typedef logic [ME_PIX_W-1:0] pix_t;

  // Pixels per incoming reference segment: one window plus the skew overlap.
  function automatic int f_in_pix(input int pe, input int rows);
    return pe + rows - 1;
  endfunction

  // Width in bits of skew stage k (it has already dropped its k lowest pixels).
  function automatic int f_stage_w(input int k, input int pe, input int rows, input int pix_w);
    return (f_in_pix(pe, rows) - k) * pix_w;
  endfunction

  // Bit offset of stage k inside a flat vector holding all stages back to back.
  function automatic int f_stage_off(input int k, input int pe, input int rows, input int pix_w);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) begin
      off += f_stage_w(j, pe, rows, pix_w);
    end
    return off;
  endfunction

endpackage

// File: rtl/me_skew_stage.sv
// One register stage of the skewed window buffer.
// Loads the top OUT_W bits of its source on an advance, which drops the lowest
// pixel(s) the source carried; the low ROW_W bits of the stored value form this
// stage's row window. Stage 0 is built with IN_W == OUT_W and drops nothing.
module me_skew_stage #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             src_vld,
  input  logic [IN_W-1:0]  src,
  output logic [OUT_W-1:0] q,
  output logic             q_vld
);

  // Pixel register: shifts on every advance whether or not the segment is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= src[IN_W-1 -: OUT_W];
    end
  end

  // Valid flag: flush wins over advance and also swallows the incoming valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld <= 1'b0;
    end else if (flush) begin
      q_vld <= 1'b0;
    end else if (en) begin
      q_vld <= src_vld;
    end
  end

endmodule

// File: rtl/me_skew_window_buf.sv
// Skewed reference-window buffer feeding the SAD PE array.
// Each advance accepts a segment of NUM_PE+NUM_ROWS-1 pixels; row r presents
// NUM_PE pixels starting at pixel r of the segment accepted r+1 advances ago.
// Optional feature macro: ME_SKEW_STAT_EN adds stat_cnt_o, a wrapping count of
// advances that leave the last row holding valid data.
module me_skew_window_buf
  import me_pkg::*;
#(
  parameter  int PIX_W    = ME_PIX_W,
  parameter  int NUM_PE   = 16,
  parameter  int NUM_ROWS = 8,
  localparam int IN_PIX   = f_in_pix(NUM_PE, NUM_ROWS),
  localparam int ROW_W    = NUM_PE * PIX_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       vld_i,
  input  logic [IN_PIX*PIX_W-1:0]    data_i,
  output logic [NUM_ROWS*ROW_W-1:0]  data_o,
  output logic [NUM_ROWS-1:0]        vld_o,
`ifdef ME_SKEW_STAT_EN
  output logic                       full_o,
  output logic [15:0]                stat_cnt_o
`else
  output logic                       full_o
`endif
);

  localparam int TOT_W = f_stage_off(NUM_ROWS, NUM_PE, NUM_ROWS, PIX_W);

  logic [TOT_W-1:0] stage_q;

  for (genvar k = 0; k < NUM_ROWS; k++) begin : g_stage
    localparam int W     = f_stage_w(k, NUM_PE, NUM_ROWS, PIX_W);
    localparam int OFF   = f_stage_off(k, NUM_PE, NUM_ROWS, PIX_W);
    localparam int SRC_W = (k == 0) ? W : f_stage_w(k - 1, NUM_PE, NUM_ROWS, PIX_W);

    logic [SRC_W-1:0] src;
    logic             src_vld;

    if (k == 0) begin : g_head
      assign src     = data_i;
      assign src_vld = vld_i;
    end else begin : g_body
      localparam int PREV_OFF = f_stage_off(k - 1, NUM_PE, NUM_ROWS, PIX_W);
      assign src     = stage_q[PREV_OFF +: SRC_W];
      assign src_vld = vld_o[k-1];
    end

    me_skew_stage #(
      .IN_W (SRC_W),
      .OUT_W(W)
    ) u_stage (
      .clk    (clk_i),
      .rst    (rst_i),
      .en     (en_i),
      .flush  (flush_i),
      .src_vld(src_vld),
      .src    (src),
      .q      (stage_q[OFF +: W]),
      .q_vld  (vld_o[k])
    );

    assign data_o[k*ROW_W +: ROW_W] = stage_q[OFF +: ROW_W];
  end

  assign full_o = vld_o[NUM_ROWS-1];

`ifdef ME_SKEW_STAT_EN
  // Counts advances after which the deepest row holds valid data; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_cnt_o <= '0;
    end else if (en_i && !flush_i && vld_o[NUM_ROWS-2]) begin
      stat_cnt_o <= stat_cnt_o + 16'd1;
    end
  end
`endif

endmodule
